// File: rtl/wavetable_voice_sched_pkg.sv
// Shared types and helpers for the wavetable voice scheduler.
// Holds the scheduler state encoding and a clog2 helper that never returns 0.
package wavetable_voice_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // A single voice still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wavetable_voice_sched_voice_phase_bank.sv
// Per-voice increment/enable/phase storage with a config write port and a
// slot read/advance port driven by the scheduler.
module voice_phase_bank
    import wavetable_voice_sched_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int ADDRWIDTH  = 12,
    parameter int PHASEWIDTH = 24,
    localparam int VW = clog2_min1(NUM_VOICES)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  cfg_we,
    input  logic [VW-1:0]         cfg_voice,
    input  logic [PHASEWIDTH-1:0] cfg_inc,
    input  logic                  cfg_enable,
    input  logic                  adv,
    input  logic [VW-1:0]         adv_idx,
    output logic [ADDRWIDTH-1:0]  rd_addr,
    output logic                  rd_enable
);

    logic [PHASEWIDTH-1:0] inc_q   [NUM_VOICES];
    logic [PHASEWIDTH-1:0] inc_d   [NUM_VOICES];
    logic [PHASEWIDTH-1:0] phase_q [NUM_VOICES];
    logic [PHASEWIDTH-1:0] phase_d [NUM_VOICES];
    logic                  en_q    [NUM_VOICES];
    logic                  en_d    [NUM_VOICES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic cfg_hit;
            logic slot_adv;

            // The slot advance uses the stored inc/enable, so a write landing
            // on the voice's own slot only takes effect next period.
            always_comb begin
                cfg_hit  = cfg_we && (cfg_voice == VW'(gi));
                slot_adv = adv && (adv_idx == VW'(gi)) && en_q[gi];
                inc_d[gi]   = inc_q[gi];
                en_d[gi]    = en_q[gi];
                phase_d[gi] = phase_q[gi];
                if (slot_adv) begin
                    phase_d[gi] = phase_q[gi] + inc_q[gi];
                end
                if (cfg_hit) begin
                    inc_d[gi] = cfg_inc;
                    en_d[gi]  = cfg_enable;
                    if (!cfg_enable) begin
                        phase_d[gi] = '0;
                    end
                end
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    inc_q[gi]   <= '0;
                    en_q[gi]    <= 1'b0;
                    phase_q[gi] <= '0;
                end else begin
                    inc_q[gi]   <= inc_d[gi];
                    en_q[gi]    <= en_d[gi];
                    phase_q[gi] <= phase_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        rd_addr   = '0;
        rd_enable = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (adv_idx == VW'(i)) begin
                rd_addr   = phase_q[i][PHASEWIDTH-1 -: ADDRWIDTH];
                rd_enable = en_q[i];
            end
        end
    end

endmodule

// File: rtl/wavetable_voice_sched.sv
// Sequences one shared 1-cycle-latency wavetable ROM across all voices per
// sample period and sums the returned samples into a single mix word.
module wavetable_voice_sched
    import wavetable_voice_sched_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int ADDRWIDTH  = 12,
    parameter int WIDTH      = 16,
    parameter int PHASEWIDTH = 24,
    localparam int VW = clog2_min1(NUM_VOICES),
    localparam int MW = WIDTH + VW
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  SampleTick,
    input  logic                  CfgWe,
    input  logic [VW-1:0]         CfgVoice,
    input  logic [PHASEWIDTH-1:0] CfgInc,
    input  logic                  CfgEnable,
    output logic                  RomCS,
    output logic [ADDRWIDTH-1:0]  RomAddr,
    input  logic [WIDTH-1:0]      RomData,
    output logic [MW-1:0]         MixOut,
    output logic                  MixValid,
    output logic                  Busy,
    output logic                  Overrun
);

    localparam logic [VW-1:0] LAST_IDX = VW'(NUM_VOICES - 1);

    sched_state_t  state_q, state_d;
    logic [VW-1:0] idx_q, idx_d;
    logic [MW-1:0] acc_q, acc_d;
    logic [MW-1:0] mix_out_q, mix_out_d;
    logic          cs_dly_q, cs_dly_d;

    logic                 issuing;
    logic [ADDRWIDTH-1:0] bank_addr;
    logic                 bank_enable;
    logic [MW-1:0]        contrib;
    logic [MW-1:0]        acc_sum;

    assign issuing = (state_q == ISSUE);

    voice_phase_bank #(
        .NUM_VOICES (NUM_VOICES),
        .ADDRWIDTH  (ADDRWIDTH),
        .PHASEWIDTH (PHASEWIDTH)
    ) u_bank (
        .Clk        (Clk),
        .Reset      (Reset),
        .cfg_we     (CfgWe),
        .cfg_voice  (CfgVoice),
        .cfg_inc    (CfgInc),
        .cfg_enable (CfgEnable),
        .adv        (issuing),
        .adv_idx    (idx_q),
        .rd_addr    (bank_addr),
        .rd_enable  (bank_enable)
    );

    assign RomCS    = issuing && bank_enable && !Reset;
    assign RomAddr  = (issuing && !Reset) ? bank_addr : '0;
    assign MixOut   = mix_out_q;
    assign MixValid = (state_q == DONE) && !Reset;
    assign Busy     = (state_q != IDLE) && !Reset;
    assign Overrun  = SampleTick && Busy;

    // Only words tagged by a chip-select one cycle earlier are summed; the ROM
    // output is undefined otherwise.
    assign contrib = cs_dly_q ? {{VW{RomData[WIDTH-1]}}, RomData} : '0;
    assign acc_sum = acc_q + contrib;
    assign cs_dly_d = RomCS;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        mix_out_d = mix_out_q;
        case (state_q)
            IDLE: begin
                if (SampleTick) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            ISSUE: begin
                acc_d = acc_sum;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                acc_d     = acc_sum;
                mix_out_d = acc_sum;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            mix_out_q <= '0;
            cs_dly_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            mix_out_q <= mix_out_d;
            cs_dly_q  <= cs_dly_d;
        end
    end

endmodule

// File: tb/tb_wavetable_voice_sched.sv
// Directed bench for wavetable_voice_sched with a behavioural 1-cycle ROM.
module tb_wavetable_voice_sched;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        SampleTick = 1'b0;
    logic        CfgWe = 1'b0;
    logic [2:0]  CfgVoice = '0;
    logic [23:0] CfgInc = '0;
    logic        CfgEnable = 1'b0;
    logic        RomCS;
    logic [11:0] RomAddr;
    logic [15:0] RomData;
    logic [18:0] MixOut;
    logic        MixValid;
    logic        Busy;
    logic        Overrun;

    logic [15:0] rom_mem [4096];
    logic        slot_cs   [8];
    logic [11:0] slot_addr [8];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 Clk = ~Clk;

    // Junk on deselected cycles stands in for the ROM's undefined output.
    always @(posedge Clk) RomData <= RomCS ? rom_mem[RomAddr] : 16'h5A5A;

    wavetable_voice_sched dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .SampleTick (SampleTick),
        .CfgWe      (CfgWe),
        .CfgVoice   (CfgVoice),
        .CfgInc     (CfgInc),
        .CfgEnable  (CfgEnable),
        .RomCS      (RomCS),
        .RomAddr    (RomAddr),
        .RomData    (RomData),
        .MixOut     (MixOut),
        .MixValid   (MixValid),
        .Busy       (Busy),
        .Overrun    (Overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic cfg(input int v, input logic [23:0] inc, input logic en);
        @(negedge Clk);
        CfgWe     = 1'b1;
        CfgVoice  = 3'(v);
        CfgInc    = inc;
        CfgEnable = en;
        @(negedge Clk);
        CfgWe = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 16'(i);
    endtask

    // Tick, then watch 20 cycles: record each ISSUE slot and the first MixValid.
    task automatic run_tick(output logic [18:0] mix, output int lat);
        lat = 0;
        mix = '0;
        @(negedge Clk);
        SampleTick = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            SampleTick = 1'b0;
            if (c <= 8) begin
                slot_cs[c-1]   = RomCS;
                slot_addr[c-1] = RomAddr;
            end
            if (MixValid && lat == 0) begin
                lat = c;
                mix = MixOut;
            end
        end
    endtask

    initial begin
        logic [18:0] mix;
        int          lat;
        int          mv_count;
        int          mv_lat;
        logic        any_cs;
        logic [11:0] exp_addr [3];

        fill_ramp();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("rst_romcs",   32'(RomCS), 32'h0);
        check_eq("rst_romaddr", 32'(RomAddr), 32'h0);
        check_eq("rst_mixout",  32'(MixOut), 32'h0);
        check_eq("rst_mixvalid", 32'(MixValid), 32'h0);
        check_eq("rst_busy",    32'(Busy), 32'h0);
        check_eq("rst_overrun", 32'(Overrun), 32'h0);

        // Single voice ramp
        cfg(0, 24'h001000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run_tick(mix, lat);
            check_eq($sformatf("t1_addr_k%0d", k), 32'(slot_addr[0]), 32'(k));
            check_eq($sformatf("t1_cs0_k%0d", k), 32'(slot_cs[0]), 32'h1);
            check_eq($sformatf("t1_cs1_k%0d", k), 32'(slot_cs[1]), 32'h0);
            check_eq($sformatf("t1_mix_k%0d", k), 32'(mix), 32'(k));
            check_eq($sformatf("t1_lat_k%0d", k), 32'(lat), 32'd10);
        end

        // All voices together, then full-scale negative samples
        do_reset();
        for (int v = 0; v < 8; v++) cfg(v, 24'h001000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run_tick(mix, lat);
            check_eq($sformatf("t2_mix_k%0d", k), 32'(mix), 32'(8 * k));
        end
        for (int i = 0; i < 4096; i++) rom_mem[i] = 16'h8000;
        run_tick(mix, lat);
        check_eq("t2_mix_negfull", 32'(mix), 32'h40000);
        fill_ramp();

        // Only voice 3 enabled
        do_reset();
        cfg(3, 24'h001000, 1'b1);
        for (int k = 0; k < 2; k++) begin
            run_tick(mix, lat);
            for (int s = 0; s < 8; s++)
                check_eq($sformatf("t3_cs_k%0d_s%0d", k, s), 32'(slot_cs[s]), 32'(s == 3));
            check_eq($sformatf("t3_mix_k%0d", k), 32'(mix), 32'(k));
        end

        // Phase wrap, then note-off clears phase
        do_reset();
        cfg(0, 24'h800000, 1'b1);
        exp_addr[0] = 12'h000;
        exp_addr[1] = 12'h800;
        exp_addr[2] = 12'h000;
        for (int k = 0; k < 3; k++) begin
            run_tick(mix, lat);
            check_eq($sformatf("t4_addr_k%0d", k), 32'(slot_addr[0]), 32'(exp_addr[k]));
            check_eq($sformatf("t4_mix_k%0d", k), 32'(mix), 32'(exp_addr[k]));
        end
        cfg(0, 24'h800000, 1'b0);
        run_tick(mix, lat);
        check_eq("t4_off_addr", 32'(slot_addr[0]), 32'h0);
        check_eq("t4_off_cs",   32'(slot_cs[0]), 32'h0);
        check_eq("t4_off_mix",  32'(mix), 32'h0);

        // Tick while busy
        do_reset();
        cfg(0, 24'h001000, 1'b1);
        mv_count = 0;
        mv_lat   = 0;
        @(negedge Clk);
        SampleTick = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge Clk);
            SampleTick = (c == 4);
            #1;
            if (c == 4) check_eq("t5_overrun_hi", 32'(Overrun), 32'h1);
            if (c == 5) check_eq("t5_overrun_lo", 32'(Overrun), 32'h0);
            if (MixValid) begin
                mv_count++;
                mv_lat = c;
            end
        end
        SampleTick = 1'b0;
        check_eq("t5_mv_count", 32'(mv_count), 32'd1);
        check_eq("t5_mv_lat",   32'(mv_lat), 32'd10);
        check_eq("t5_idle",     32'(Busy), 32'h0);

        // Reset mid-ISSUE
        do_reset();
        for (int v = 0; v < 8; v++) cfg(v, 24'h001000, 1'b1);
        mv_count = 0;
        @(negedge Clk);
        SampleTick = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            SampleTick = 1'b0;
            if (c == 5) Reset = 1'b1;
            if (c == 6) begin
                Reset = 1'b0;
                #1;
                check_eq("t6_busy",  32'(Busy), 32'h0);
                check_eq("t6_romcs", 32'(RomCS), 32'h0);
            end
            if (c >= 6 && MixValid) mv_count++;
        end
        check_eq("t6_no_mixvalid", 32'(mv_count), 32'd0);
        run_tick(mix, lat);
        any_cs = 1'b0;
        for (int s = 0; s < 8; s++) any_cs = any_cs | slot_cs[s];
        check_eq("t6_enables_cleared", 32'(any_cs), 32'h0);
        check_eq("t6_phase0_cleared",  32'(slot_addr[0]), 32'h0);
        check_eq("t6_mix_zero",        32'(mix), 32'h0);
        check_eq("t6_lat",             32'(lat), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
